// File: rtl/h14tx_period_sched.sv
// h14tx_pkg + h14tx_period_sched
//
// Purpose: raster and period scheduler for the HDMI 1.4 transmitter. It
// produces the pixel x/y position, syncs, the HDMI period sequence (Control,
// Video preamble/guard/Video, Data preamble/guard/Data) and the data-island
// packet timing with a valid/ready handshake to the packet source.
//
// Ports:
//   pixel_clk    in   pixel clock
//   rst_n        in   asynchronous reset, active low
//   pkt_valid    in   packet source has a packet to send
//   pkt_ready    out  packet slot offered; transfer = pkt_valid & pkt_ready
//   x, y         out  pixel column / line
//   period       out  current HDMI period (h14tx_pkg::period_t)
//   ctl          out  per-channel control bits, ctl[0] = {vsync, hsync}
//   pkt_phase    out  cycle 0..31 within the current packet, 0 outside Data
//   island_last  out  final Data cycle of an island
//
// x, y, period, ctl, pkt_ready and pkt_phase are registered together, so
// one cycle always describes one pixel.

package h14tx_pkg;
  typedef logic [2:0] period_t;
  localparam period_t PER_CONTROL     = 3'd0;
  localparam period_t PER_VIDEO_PRE   = 3'd1;
  localparam period_t PER_VIDEO_GUARD = 3'd2;
  localparam period_t PER_VIDEO       = 3'd3;
  localparam period_t PER_DATA_PRE    = 3'd4;
  localparam period_t PER_DATA_GUARD  = 3'd5;
  localparam period_t PER_DATA        = 3'd6;
endpackage

module h14tx_period_sched
  import h14tx_pkg::*;
#(
  parameter int   H_TOTAL     = 1650,
  parameter int   V_TOTAL     = 750,
  parameter int   H_ACTIVE    = 1280,
  parameter int   V_ACTIVE    = 720,
  parameter int   H_FRONT     = 110,
  parameter int   H_SYNC      = 40,
  parameter int   V_FRONT     = 5,
  parameter int   V_SYNC      = 5,
  parameter logic SYNC_POL    = 1'b1,
  parameter logic DVI_MODE    = 1'b0,
  parameter int   MAX_PACKETS = 2,
  parameter int   ISLAND_GAP  = 12,
  parameter int   XW          = $clog2(H_TOTAL),
  parameter int   YW          = $clog2(V_TOTAL)
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  input  logic           pkt_valid,
  output logic           pkt_ready,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output period_t        period,
  output logic [2:0][1:0] ctl,
  output logic [4:0]     pkt_phase,
  output logic           island_last
);

  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int X0  = H_ACTIVE + ISLAND_GAP;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_VP   = XW'(H_TOTAL - 10);
  localparam logic [XW-1:0] X_VG   = XW'(H_TOTAL - 2);
  localparam logic [XW-1:0] X_DEC  = XW'(X0 - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  // Sync bounds carry one extra bit: the end bound may equal the total.
  localparam logic [XW:0]   HS_BEG = XW1'(H_ACTIVE + H_FRONT);
  localparam logic [XW:0]   HS_END = XW1'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW:0]   VS_BEG = YW1'(V_ACTIVE + V_FRONT);
  localparam logic [YW:0]   VS_END = YW1'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [4:0]    MAX_P  = 5'(MAX_PACKETS);

  if (X0 + 8 + 2 + 32 * MAX_PACKETS + 2 + 12 > H_TOTAL - 10) begin : g_chk_island
    $error("data island does not fit before the video lead-in");
  end
  if (H_ACTIVE + H_FRONT + H_SYNC > H_TOTAL) begin : g_chk_h
    $error("horizontal timing exceeds H_TOTAL");
  end
  if (V_ACTIVE + V_FRONT + V_SYNC > V_TOTAL) begin : g_chk_v
    $error("vertical timing exceeds V_TOTAL");
  end
  if (MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_chk_pkts
    $error("MAX_PACKETS must be 1..18");
  end

  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d, y_nl;
  period_t        period_q, period_d;
  logic [2:0][1:0] ctl_q, ctl_d;
  logic           pkt_ready_q, pkt_ready_d;
  logic [4:0]     pkt_phase_q, pkt_phase_d;
  logic [4:0]     pkt_cnt_q, pkt_cnt_d;   // packets in this island incl. current
  logic [2:0]     seg_q, seg_d;           // cycle index in preamble / guard
  logic           trail_q, trail_d;       // current DataGuard is the trailing one
  logic           hs_d, vs_d, xfer;

  assign xfer = pkt_valid & pkt_ready_q;

  always_comb begin
    // Position of the pixel the next cycle describes.
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
    end
    y_nl = (y_d == Y_LAST) ? '0 : y_d + YW'(1);
    hs_d = ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END);
    vs_d = ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END);

    // Raster-driven period; a running island overrides it below.
    period_d = PER_CONTROL;
    if (x_d < X_ACT && y_d < Y_ACT)
      period_d = PER_VIDEO;
    else if (!DVI_MODE && y_nl < Y_ACT && x_d >= X_VP)
      period_d = (x_d >= X_VG) ? PER_VIDEO_GUARD : PER_VIDEO_PRE;

    seg_d       = '0;
    trail_d     = trail_q;
    pkt_cnt_d   = pkt_cnt_q;
    pkt_phase_d = '0;
    if (!DVI_MODE) begin
      case (period_q)
        PER_DATA_PRE: begin
          if (seg_q == 3'd7) begin
            period_d = PER_DATA_GUARD;
            trail_d  = 1'b0;
          end else begin
            period_d = PER_DATA_PRE;
            seg_d    = seg_q + 3'd1;
          end
        end
        PER_DATA_GUARD: begin
          if (seg_q == 3'd0) begin
            period_d = PER_DATA_GUARD;
            seg_d    = 3'd1;
          end else if (!trail_q) begin
            period_d  = PER_DATA;
            pkt_cnt_d = 5'd1;
          end
          // end of trailing guard: raster period (Control) takes over
        end
        PER_DATA: begin
          period_d = PER_DATA;
          if (pkt_phase_q == 5'd31) begin
            if (xfer) begin
              pkt_cnt_d = pkt_cnt_q + 5'd1;
            end else begin
              period_d = PER_DATA_GUARD;
              trail_d  = 1'b1;
            end
          end else begin
            pkt_phase_d = pkt_phase_q + 5'd1;
          end
        end
        default: begin
          // Outside an island pkt_ready is only high on the decision cycle.
          if (xfer) period_d = PER_DATA_PRE;
        end
      endcase
    end

    pkt_ready_d = !DVI_MODE &&
                  ((x_d == X_DEC && period_d == PER_CONTROL) ||
                   (period_d == PER_DATA && pkt_phase_d == 5'd31 && pkt_cnt_d < MAX_P));

    ctl_d[0] = {vs_d ^ ~SYNC_POL, hs_d ^ ~SYNC_POL};
    ctl_d[1] = (period_d == PER_VIDEO_PRE || period_d == PER_DATA_PRE) ? 2'b01 : 2'b00;
    ctl_d[2] = (period_d == PER_DATA_PRE) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      period_q    <= PER_CONTROL;
      ctl_q[0]    <= {~SYNC_POL, ~SYNC_POL};
      ctl_q[1]    <= 2'b00;
      ctl_q[2]    <= 2'b00;
      pkt_ready_q <= 1'b0;
      pkt_phase_q <= '0;
      pkt_cnt_q   <= '0;
      seg_q       <= '0;
      trail_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      period_q    <= period_d;
      ctl_q       <= ctl_d;
      pkt_ready_q <= pkt_ready_d;
      pkt_phase_q <= pkt_phase_d;
      pkt_cnt_q   <= pkt_cnt_d;
      seg_q       <= seg_d;
      trail_q     <= trail_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign period    = period_q;
  assign ctl       = ctl_q;
  assign pkt_ready = pkt_ready_q;
  assign pkt_phase = pkt_phase_q;
  // The island ends exactly when the offered slot goes unused, which is only
  // known from the live pkt_valid on that cycle.
  assign island_last = (period_q == PER_DATA) && (pkt_phase_q == 5'd31) && !xfer;

endmodule
